// File: rtl/bank_timing_guard_pkg.sv
// Shared types and default DRAM timing constants for the per-bank timing guard.
// Encodings of recode_state_t match the existing controller's last-command codes.
package bank_timing_guard_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_t;

    typedef enum logic [1:0] {
        BS_CLOSED  = 2'd0,
        BS_OPEN    = 2'd1,
        BS_AP_PEND = 2'd2,
        BS_REFRESH = 2'd3
    } bank_state_t;

    typedef enum logic [2:0] {
        RS_NONE              = 3'd0,
        ACTIVE_TO_READ_WRITE = 3'd1,
        READ_TO_PRECHARGE    = 3'd2,
        WRITE_TO_PRECHARGE   = 3'd3,
        PRECHARGE_TO_ACTIVE  = 3'd4,
        PRECHARGE_TO_REFRESH = 3'd5
    } recode_state_t;

    localparam int DEF_T_RCD = 11;
    localparam int DEF_T_RAS = 28;
    localparam int DEF_T_RC  = 39;
    localparam int DEF_T_RP  = 11;
    localparam int DEF_T_RTP = 6;
    localparam int DEF_T_WR  = 12;
    localparam int DEF_T_WL  = 9;
    localparam int DEF_T_RFC = 44;

endpackage

// File: rtl/bank_timing_guard_sat_down_counter.sv
// Loadable down-counter that saturates at zero; load has priority over decrement.
module sat_down_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/bank_timing_guard.sv
// Per-bank DRAM timing guard: tracks bank state and seven independent timers,
// and reports zero-latency command-legal flags, last command and a sticky violation.
module bank_timing_guard
    import bank_timing_guard_pkg::*;
#(
    parameter int BA_W    = 3,
    parameter int BANK_ID = 0,
    parameter int CNT_W   = 6,
    parameter int T_RCD   = DEF_T_RCD,
    parameter int T_RAS   = DEF_T_RAS,
    parameter int T_RC    = DEF_T_RC,
    parameter int T_RP    = DEF_T_RP,
    parameter int T_RTP   = DEF_T_RTP,
    parameter int T_WR    = DEF_T_WR,
    parameter int T_WL    = DEF_T_WL,
    parameter int T_RFC   = DEF_T_RFC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    input  logic [2:0]      cmd,
    input  logic [BA_W-1:0] cmd_bank,
    input  logic            auto_pre,
    input  logic            bl4,
    output logic            act_ok,
    output logic            rdwr_ok,
    output logic            pre_ok,
    output logic            ref_ok,
    output logic [1:0]      bank_st,
    output logic [2:0]      last_cmd,
    output logic            violation
);

    localparam int LIMIT    = 2 ** CNT_W;
    localparam int LD_WR8_I = T_WL + 4 + T_WR - 1;
    localparam int LD_WR4_I = T_WL + 2 + T_WR - 1;

    if ((T_RCD - 1 >= LIMIT) || (T_RAS - 1 >= LIMIT) || (T_RC - 1 >= LIMIT) ||
        (T_RP - 1 >= LIMIT) || (T_RTP - 1 >= LIMIT) || (T_RFC - 1 >= LIMIT) ||
        (LD_WR8_I >= LIMIT) || (LD_WR4_I >= LIMIT)) begin : g_param_check
        $error("bank_timing_guard: a timer load value does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] LD_RAS = CNT_W'(T_RAS - 1);
    localparam logic [CNT_W-1:0] LD_RC  = CNT_W'(T_RC - 1);
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_RTP = CNT_W'(T_RTP - 1);
    localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] LD_WR8 = CNT_W'(LD_WR8_I);
    localparam logic [CNT_W-1:0] LD_WR4 = CNT_W'(LD_WR4_I);

    cmd_t          w_cmd;
    logic          w_hit;
    logic          w_act, w_rd, w_wr, w_pre, w_ref;
    logic          w_ap_done;
    logic          w_rcd_z, w_ras_z, w_rc_z, w_rp_z, w_rtp_z, w_wr_z, w_rfc_z;
    logic          w_viol;
    bank_state_t   r_state, w_state_nxt;
    recode_state_t r_last_cmd;
    logic          r_violation;

    assign w_cmd = cmd_t'(cmd);
    // REF is all-bank, so it hits this instance whatever cmd_bank carries
    assign w_hit = cmd_valid & ((w_cmd == CMD_REF) | (cmd_bank == BA_W'(BANK_ID)));
    assign w_act = w_hit & (w_cmd == CMD_ACT);
    assign w_rd  = w_hit & (w_cmd == CMD_RD);
    assign w_wr  = w_hit & (w_cmd == CMD_WR);
    assign w_pre = w_hit & (w_cmd == CMD_PRE);
    assign w_ref = w_hit & (w_cmd == CMD_REF);

    assign w_ap_done = (r_state == BS_AP_PEND) & w_ras_z & w_rtp_z & w_wr_z;

    sat_down_counter #(.CNT_W(CNT_W)) u_rcd (
        .clk(clk), .rst_n(rst_n), .i_load(w_act), .i_value(LD_RCD), .o_zero(w_rcd_z));
    sat_down_counter #(.CNT_W(CNT_W)) u_ras (
        .clk(clk), .rst_n(rst_n), .i_load(w_act), .i_value(LD_RAS), .o_zero(w_ras_z));
    sat_down_counter #(.CNT_W(CNT_W)) u_rc (
        .clk(clk), .rst_n(rst_n), .i_load(w_act), .i_value(LD_RC), .o_zero(w_rc_z));
    sat_down_counter #(.CNT_W(CNT_W)) u_rp (
        .clk(clk), .rst_n(rst_n), .i_load(w_pre | w_ap_done), .i_value(LD_RP), .o_zero(w_rp_z));
    sat_down_counter #(.CNT_W(CNT_W)) u_rtp (
        .clk(clk), .rst_n(rst_n), .i_load(w_rd), .i_value(LD_RTP), .o_zero(w_rtp_z));
    sat_down_counter #(.CNT_W(CNT_W)) u_wr (
        .clk(clk), .rst_n(rst_n), .i_load(w_wr), .i_value(bl4 ? LD_WR4 : LD_WR8),
        .o_zero(w_wr_z));
    sat_down_counter #(.CNT_W(CNT_W)) u_rfc (
        .clk(clk), .rst_n(rst_n), .i_load(w_ref), .i_value(LD_RFC), .o_zero(w_rfc_z));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BS_CLOSED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Timing-illegal commands still follow the FSM edges; only the flags judge timing
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BS_CLOSED: begin
                if (w_act) begin
                    w_state_nxt = BS_OPEN;
                end else if (w_ref) begin
                    w_state_nxt = BS_REFRESH;
                end
            end
            BS_OPEN: begin
                if (w_pre) begin
                    w_state_nxt = BS_CLOSED;
                end else if ((w_rd | w_wr) & auto_pre) begin
                    w_state_nxt = BS_AP_PEND;
                end
            end
            BS_AP_PEND: begin
                if (w_ap_done) begin
                    w_state_nxt = BS_CLOSED;
                end
            end
            BS_REFRESH: begin
                if (w_rfc_z) begin
                    w_state_nxt = BS_CLOSED;
                end
            end
            default: w_state_nxt = BS_CLOSED;
        endcase
    end

    always_comb begin
        act_ok  = 1'b0;
        rdwr_ok = 1'b0;
        pre_ok  = 1'b0;
        ref_ok  = 1'b0;
        case (r_state)
            BS_CLOSED: begin
                act_ok = w_rp_z & w_rc_z & w_rfc_z;
                ref_ok = w_rp_z & w_rfc_z;
                pre_ok = 1'b1;
            end
            BS_OPEN: begin
                rdwr_ok = w_rcd_z;
                pre_ok  = w_ras_z & w_rtp_z & w_wr_z;
            end
            default: ;
        endcase
    end

    assign w_viol = (w_act & ~act_ok) | ((w_rd | w_wr) & ~rdwr_ok) |
                    (w_pre & ~pre_ok) | (w_ref & ~ref_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_violation <= 1'b0;
        end else if (w_viol) begin
            r_violation <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_cmd <= RS_NONE;
        end else if (w_act) begin
            r_last_cmd <= ACTIVE_TO_READ_WRITE;
        end else if (w_rd) begin
            r_last_cmd <= READ_TO_PRECHARGE;
        end else if (w_wr) begin
            r_last_cmd <= WRITE_TO_PRECHARGE;
        end else if (w_pre | w_ap_done) begin
            r_last_cmd <= PRECHARGE_TO_ACTIVE;
        end else if (w_ref) begin
            r_last_cmd <= PRECHARGE_TO_REFRESH;
        end
    end

    assign bank_st   = r_state;
    assign last_cmd  = r_last_cmd;
    assign violation = r_violation;

endmodule

// File: tb/tb_bank_timing_guard.sv
// Directed bench for bank_timing_guard (bank 0, default timings); k = posedges since
// the most recent ACT/REF origin, outputs sampled 1 time unit after each posedge.
module tb_bank_timing_guard;
    import bank_timing_guard_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [2:0] cmd_bank;
    logic       auto_pre;
    logic       bl4;
    logic       act_ok, rdwr_ok, pre_ok, ref_ok;
    logic [1:0] bank_st;
    logic [2:0] last_cmd;
    logic       violation;

    int checks   = 0;
    int failures = 0;

    bank_timing_guard #(.BA_W(3), .BANK_ID(0)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank),
        .auto_pre(auto_pre), .bl4(bl4), .act_ok(act_ok), .rdwr_ok(rdwr_ok), .pre_ok(pre_ok),
        .ref_ok(ref_ok), .bank_st(bank_st), .last_cmd(last_cmd), .violation(violation)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input logic [2:0] c, input logic [2:0] b, input logic ap, input logic b4);
        cmd_valid = 1'b1;
        cmd       = c;
        cmd_bank  = b;
        auto_pre  = ap;
        bl4       = b4;
        tick();
        cmd_valid = 1'b0;
        cmd       = 3'd0;
        cmd_bank  = 3'd0;
        auto_pre  = 1'b0;
        bl4       = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_act_ok"},  8'(act_ok),    8'd1);
        chk({tag, "_rdwr_ok"}, 8'(rdwr_ok),   8'd0);
        chk({tag, "_pre_ok"},  8'(pre_ok),    8'd1);
        chk({tag, "_ref_ok"},  8'(ref_ok),    8'd1);
        chk({tag, "_bank_st"}, 8'(bank_st),   8'd0);
        chk({tag, "_last"},    8'(last_cmd),  8'd0);
        chk({tag, "_viol"},    8'(violation), 8'd0);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; cmd_bank = 3'd0;
        auto_pre = 1'b0; bl4 = 1'b0;
        idle(2);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        idle(1);

        // ACT -> RD at tRCD -> PRE at tRAS -> ACT allowed at tRC
        issue(3'(CMD_ACT), 3'd0, 1'b0, 1'b0);
        chk("t1_st_open",  8'(bank_st),  8'd1);
        chk("t1_last_act", 8'(last_cmd), 8'd1);
        chk("t1_act_ok0",  8'(act_ok),   8'd0);
        chk("t1_pre_ok0",  8'(pre_ok),   8'd0);
        idle(9);
        chk("t1_rdwr_k9",  8'(rdwr_ok),  8'd0);
        idle(1);
        chk("t1_rdwr_k10", 8'(rdwr_ok),  8'd1);
        issue(3'(CMD_RD), 3'd0, 1'b0, 1'b0);
        chk("t1_last_rd",  8'(last_cmd), 8'd2);
        idle(15);
        chk("t1_pre_k26",  8'(pre_ok),   8'd0);
        idle(1);
        chk("t1_pre_k27",  8'(pre_ok),   8'd1);
        issue(3'(CMD_PRE), 3'd0, 1'b0, 1'b0);
        chk("t2_st_closed", 8'(bank_st),  8'd0);
        chk("t2_last_pre",  8'(last_cmd), 8'd4);
        idle(9);
        chk("t2_act_k37",  8'(act_ok),    8'd0);
        idle(1);
        chk("t2_act_k38",  8'(act_ok),    8'd1);
        chk("t2_viol",     8'(violation), 8'd0);

        // BL8 write with auto-precharge
        issue(3'(CMD_ACT), 3'd0, 1'b0, 1'b0);
        idle(10);
        issue(3'(CMD_WR), 3'd0, 1'b1, 1'b0);
        chk("t3_st_ap",    8'(bank_st),  8'd2);
        chk("t3_last_wr",  8'(last_cmd), 8'd3);
        idle(24);
        chk("t3_st_ap_k35", 8'(bank_st), 8'd2);
        idle(1);
        chk("t3_st_cl_k36", 8'(bank_st), 8'd0);
        chk("t3_last_apc",  8'(last_cmd), 8'd4);
        idle(9);
        chk("t3_act_k45",  8'(act_ok),   8'd0);
        idle(1);
        chk("t3_act_k46",  8'(act_ok),   8'd1);

        // BC4 write with auto-precharge: two cycles shorter
        issue(3'(CMD_ACT), 3'd0, 1'b0, 1'b0);
        idle(10);
        issue(3'(CMD_WR), 3'd0, 1'b1, 1'b1);
        idle(22);
        chk("t3b_st_ap_k33", 8'(bank_st), 8'd2);
        idle(1);
        chk("t3b_st_cl_k34", 8'(bank_st), 8'd0);
        idle(9);
        chk("t3b_act_k43",   8'(act_ok),  8'd0);
        idle(1);
        chk("t3b_act_k44",   8'(act_ok),  8'd1);

        // REF addressed to another bank still hits
        issue(3'(CMD_REF), 3'd5, 1'b0, 1'b0);
        chk("t4_st_ref",   8'(bank_st),  8'd3);
        chk("t4_last_ref", 8'(last_cmd), 8'd5);
        chk("t4_ref_ok0",  8'(ref_ok),   8'd0);
        idle(43);
        chk("t4_act_k43",  8'(act_ok),   8'd0);
        chk("t4_ref_k43",  8'(ref_ok),   8'd0);
        chk("t4_st_k43",   8'(bank_st),  8'd3);
        idle(1);
        chk("t4_st_k44",   8'(bank_st),  8'd0);
        chk("t4_act_k44",  8'(act_ok),   8'd1);
        chk("t4_ref_k44",  8'(ref_ok),   8'd1);
        issue(3'(CMD_ACT), 3'd3, 1'b0, 1'b0);
        chk("t4_other_st",   8'(bank_st),   8'd0);
        chk("t4_other_last", 8'(last_cmd),  8'd5);
        chk("t4_other_viol", 8'(violation), 8'd0);

        // Early RD sets sticky violation
        issue(3'(CMD_ACT), 3'd0, 1'b0, 1'b0);
        idle(4);
        issue(3'(CMD_RD), 3'd0, 1'b0, 1'b0);
        chk("t5_viol_set", 8'(violation), 8'd1);
        chk("t5_st_open",  8'(bank_st),   8'd1);
        idle(5);
        chk("t5_rdwr_k10", 8'(rdwr_ok),   8'd1);
        issue(3'(CMD_RD), 3'd0, 1'b0, 1'b0);
        chk("t5_viol_sticky", 8'(violation), 8'd1);

        // Async reset mid-AP_PEND and mid-REFRESH
        issue(3'(CMD_WR), 3'd0, 1'b1, 1'b0);
        chk("t6_st_ap", 8'(bank_st), 8'd2);
        idle(3);
        rst_n = 1'b0;
        #2;
        chk_reset_vals("t6_rst_ap");
        tick();
        rst_n = 1'b1;
        issue(3'(CMD_REF), 3'd0, 1'b0, 1'b0);
        chk("t6_st_ref", 8'(bank_st), 8'd3);
        idle(10);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_ref_st",  8'(bank_st), 8'd0);
        chk("t6_rst_ref_act", 8'(act_ok),  8'd1);
        chk("t6_rst_ref_ref", 8'(ref_ok),  8'd1);
        tick();
        rst_n = 1'b1;

        // PRE to a closed bank is legal and reloads tRP
        issue(3'(CMD_PRE), 3'd0, 1'b0, 1'b0);
        chk("t7_st",   8'(bank_st),   8'd0);
        chk("t7_viol", 8'(violation), 8'd0);
        chk("t7_last", 8'(last_cmd),  8'd4);
        chk("t7_act0", 8'(act_ok),    8'd0);
        idle(9);
        chk("t7_act_k9",  8'(act_ok), 8'd0);
        idle(1);
        chk("t7_act_k10", 8'(act_ok), 8'd1);
        issue(3'(CMD_ACT), 3'd0, 1'b0, 1'b0);
        chk("t7_st_open", 8'(bank_st),   8'd1);
        chk("t7_viol_end", 8'(violation), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
